bchecc_chien_ctrl: RTL

Chien-search sequencer for the BCH decoder over GF(2^13). It owns the 15-lane GF multiplier bank (bchecc_gfmult15) during the root search. It loads the error-locator coefficients lambda1..lambda15 from the BM stage and steps them by alpha^k once per codeword position. It reports each root position to the correction stage over a valid/ready handshake, then flags success or failure.

---
 rtl/bchecc_chien_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bchecc_chien_ctrl.sv
`default_nettype none
// ============================================================================
// bchecc_chien_ctrl : Chien-search sequencer stepping lambda1..15 by alpha^k
//                     through the shared 15-lane GF(2^13) multiplier bank.
// Revision 1.0
// ============================================================================
module bchecc_chien_ctrl #(
  parameter int GF_M  = 13,
  parameter int T_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [GF_M*T_MAX-1:0]   lambda_i,
  input  logic [3:0]              deg_i,
  input  logic [GF_M-1:0]         len_i,
  output logic [GF_M*T_MAX-1:0]   mult_a_o,
  output logic [GF_M*T_MAX-1:0]   mult_b_o,
  input  logic [GF_M*T_MAX-1:0]   mult_s_i,
  output logic                    loc_valid_o,
  input  logic                    loc_ready_i,
  output logic [GF_M-1:0]         loc_pos_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [3:0]              err_num_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [GF_M-1:0] ONE  = {{(GF_M-1){1'b0}}, 1'b1};
  // Low-order terms of x^13+x^4+x^3+x+1, folded back in when alpha*v overflows.
  localparam logic [GF_M-1:0] POLY = {{(GF_M-5){1'b0}}, 5'b11011};

  function automatic logic [GF_M-1:0] alpha_pow(input int k);
    logic [GF_M-1:0] v;
    v = ONE;
    for (int i = 0; i < k; i++) begin
      v = v[GF_M-1] ? ((v << 1) ^ POLY) : (v << 1);
    end
    return v;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [GF_M-1:0] reg_q [T_MAX];
  logic [GF_M-1:0] reg_d [T_MAX];
  logic [GF_M-1:0] pos_q, pos_d;
  logic [GF_M-1:0] len_q, len_d;
  logic [GF_M-1:0] loc_pos_q, loc_pos_d;
  logic [3:0]      deg_q, deg_d;
  logic [3:0]      found_q, found_d;
  logic [3:0]      err_num_q, err_num_d;
  logic            loc_valid_q, loc_valid_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;

  logic [GF_M-1:0] sum;
  logic [3:0]      found_inc;

  generate
    for (genvar k = 0; k < T_MAX; k++) begin : g_lane
      localparam logic [GF_M-1:0] ALPHA_K = alpha_pow(k + 1);
      assign mult_a_o[GF_M*k +: GF_M] = reg_q[k];
      assign mult_b_o[GF_M*k +: GF_M] = ALPHA_K;
    end
  endgenerate

  // Locator evaluated at the current position: 1 + sum of stepped terms.
  always_comb begin
    sum = ONE;
    for (int k = 0; k < T_MAX; k++) begin
      sum = sum ^ reg_q[k];
    end
  end

  assign found_inc = (found_q == 4'hF) ? found_q : found_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    pos_d       = pos_q;
    len_d       = len_q;
    deg_d       = deg_q;
    found_d     = found_q;
    loc_pos_d   = loc_pos_q;
    loc_valid_d = loc_valid_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    err_num_d   = err_num_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          for (int k = 0; k < T_MAX; k++) begin
            reg_d[k] = (k < int'(deg_i)) ? lambda_i[GF_M*k +: GF_M] : '0;
          end
          deg_d     = deg_i;
          len_d     = len_i;
          pos_d     = '0;
          found_d   = '0;
          fail_d    = 1'b0;
          err_num_d = '0;
          if (deg_i == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEARCH;
          end
        end
      end

      S_SEARCH: begin
        for (int k = 0; k < T_MAX; k++) begin
          reg_d[k] = mult_s_i[GF_M*k +: GF_M];
        end
        pos_d = pos_q + ONE;
        if (sum == '0) begin
          found_d     = found_inc;
          loc_pos_d   = pos_q;
          loc_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (pos_q == len_q - ONE) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          fail_d    = (found_q != deg_q);
          err_num_d = found_q;
        end
      end

      S_OUT: begin
        if (loc_ready_i) begin
          loc_valid_d = 1'b0;
          if (found_q == deg_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            fail_d    = 1'b0;
            err_num_d = found_q;
          end else if (pos_q == len_q) begin
            // Root sat on the last position; fewer roots than the degree.
            state_d   = S_DONE;
            done_d    = 1'b1;
            fail_d    = 1'b1;
            err_num_d = found_q;
          end else begin
            state_d = S_SEARCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < T_MAX; k++) begin
        reg_q[k] <= '0;
      end
      pos_q       <= '0;
      len_q       <= '0;
      deg_q       <= '0;
      found_q     <= '0;
      loc_pos_q   <= '0;
      loc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_num_q   <= '0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      deg_q       <= deg_d;
      found_q     <= found_d;
      loc_pos_q   <= loc_pos_d;
      loc_valid_q <= loc_valid_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      err_num_q   <= err_num_d;
    end
  end

  assign busy_o      = (state_q == S_SEARCH) || (state_q == S_OUT);
  assign loc_valid_o = loc_valid_q;
  assign loc_pos_o   = loc_pos_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign err_num_o   = err_num_q;

endmodule
`default_nettype wire
